// File: rtl/bus_arbiter_pkg.sv
// bus_arbiter_pkg: shared state encoding and sizing for the round-robin bus arbiter.
package bus_arbiter_pkg;
  localparam int MAX_MASTERS = 8;
  localparam int IDX_W = 3;
  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    GRANT      = 2'd1,
    WAIT_BEGIN = 2'd2,
    ACTIVE     = 2'd3
  } arbState_t;
endpackage

// File: rtl/rr_priority_select.sv
// rr_priority_select: picks the first requester scanning upward from lastIdx+1, wrapping at N.
module rr_priority_select
  import bus_arbiter_pkg::*;
#(
  parameter int N = 4
) (
  input  logic [N-1:0]     request,
  input  logic [IDX_W-1:0] lastIdx,
  output logic [IDX_W-1:0] winner,
  output logic             valid
);
  logic [MAX_MASTERS-1:0] reqPad;
  logic [IDX_W:0]         pos;
  always_comb begin
    reqPad = MAX_MASTERS'(request);
    pos    = '0;
    winner = '0;
    valid  = 1'b0;
    // Walk from farthest to nearest so the nearest hit overrides.
    for (int k = N; k >= 1; k--) begin
      pos = {1'b0, lastIdx} + (IDX_W + 1)'(k);
      if (pos >= (IDX_W + 1)'(N)) pos = pos - (IDX_W + 1)'(N);
      if (reqPad[pos[IDX_W-1:0]]) begin
        winner = pos[IDX_W-1:0];
        valid  = 1'b1;
      end
    end
  end
endmodule

// File: rtl/bus_arbiter_rr.sv
// bus_arbiter_rr: round-robin grant and begin/end tracking for the shared address/data bus.
// Optional transaction watchdog enabled by BUS_ARBITER_WATCHDOG_EN.
module bus_arbiter_rr
  import bus_arbiter_pkg::*;
#(
  parameter int NR_MASTERS      = 4,
  parameter int BEGIN_TIMEOUT   = 4,
  parameter int WATCHDOG_CYCLES = 255
) (
  input  logic                  clock,
  input  logic                  nReset,
  input  logic [NR_MASTERS-1:0] requestIn,
  output logic [NR_MASTERS-1:0] grantOut,
  input  logic                  beginTransactionIn,
  input  logic                  endTransactionIn,
  input  logic                  dataValidIn,
  input  logic                  busErrorIn,
  output logic                  endTransactionOut,
  output logic                  busErrorOut,
  output logic [IDX_W-1:0]      activeMasterOut,
  output logic                  busIdleOut
);
  arbState_t             state, stateNext;
  logic [3:0]            beginCnt, beginCntNext;
  logic [NR_MASTERS-1:0] grantNext;
  logic [IDX_W-1:0]      activeNext, winner;
  logic                  winValid;
  logic                  unusedIn;
  assign unusedIn = ^{busErrorIn, dataValidIn, 10'(WATCHDOG_CYCLES)};
`ifdef BUS_ARBITER_WATCHDOG_EN
  logic [9:0] wdCnt, wdCntNext;
  logic       fireNext;
`endif

  rr_priority_select #(.N(NR_MASTERS)) uSelect (
    .request(requestIn),
    .lastIdx(activeMasterOut),
    .winner (winner),
    .valid  (winValid)
  );

  always_comb begin
    stateNext    = state;
    beginCntNext = beginCnt;
    grantNext    = '0;
    activeNext   = activeMasterOut;
`ifdef BUS_ARBITER_WATCHDOG_EN
    wdCntNext    = wdCnt;
    fireNext     = 1'b0;
`endif
    case (state)
      IDLE: if (winValid) begin
        stateNext  = GRANT;
        grantNext  = NR_MASTERS'(1) << winner;
        activeNext = winner;
      end
      GRANT: begin
        stateNext    = WAIT_BEGIN;
        beginCntNext = 4'd1;
      end
      WAIT_BEGIN: begin
        // A silent timeout still leaves the turn consumed via activeMasterOut.
        if (beginTransactionIn) stateNext = endTransactionIn ? IDLE : ACTIVE;
        else if (beginCnt == 4'(BEGIN_TIMEOUT)) stateNext = IDLE;
        else beginCntNext = beginCnt + 4'd1;
`ifdef BUS_ARBITER_WATCHDOG_EN
        wdCntNext = '0;
`endif
      end
      ACTIVE: begin
`ifdef BUS_ARBITER_WATCHDOG_EN
        // The forced-end pulse cycle itself is the last ACTIVE cycle.
        if (endTransactionIn || endTransactionOut) stateNext = IDLE;
        else begin
          wdCntNext = dataValidIn ? '0 : wdCnt + 10'd1;
          fireNext  = !dataValidIn && wdCnt == 10'(WATCHDOG_CYCLES - 1);
        end
`else
        if (endTransactionIn) stateNext = IDLE;
`endif
      end
    endcase
  end

  always_ff @(posedge clock or negedge nReset) begin
    if (!nReset) begin
      state           <= IDLE;
      beginCnt        <= '0;
      grantOut        <= '0;
      activeMasterOut <= IDX_W'(NR_MASTERS - 1);
      busIdleOut      <= 1'b1;
    end else begin
      state           <= stateNext;
      beginCnt        <= beginCntNext;
      grantOut        <= grantNext;
      activeMasterOut <= activeNext;
      busIdleOut      <= stateNext == IDLE;
    end
  end

`ifdef BUS_ARBITER_WATCHDOG_EN
  always_ff @(posedge clock or negedge nReset) begin
    if (!nReset) begin
      wdCnt             <= '0;
      endTransactionOut <= 1'b0;
      busErrorOut       <= 1'b0;
    end else begin
      wdCnt             <= wdCntNext;
      endTransactionOut <= fireNext;
      busErrorOut       <= fireNext;
    end
  end
`else
  assign endTransactionOut = 1'b0;
  assign busErrorOut       = 1'b0;
`endif
endmodule
